// File: rtl/debounce_pkg.sv
// debounce_pkg: shared definitions for the debounce / edge-detect block.
//   - state_e     : 2-bit FSM encoding shared by RTL and anyone decoding it
//   - DEF_*       : default qualification times for a 100 MHz clock
//   - max_int     : helper used to size the shared counter width
package debounce_pkg;

  typedef enum logic [1:0] {
    IDLE_LOW  = 2'b00,
    WAIT_HIGH = 2'b01,
    IDLE_HIGH = 2'b10,
    WAIT_LOW  = 2'b11
  } state_e;

  // 10 ms and 1 s at 100 MHz.
  localparam int DEF_DEBOUNCE_CYCLES = 1_000_000;
  localparam int DEF_LONG_CYCLES     = 100_000_000;

  function automatic int max_int(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/debounce_edge_detect_if.sv
// debounce_edge_detect_if: signal bundle between the input synchronizer,
// the debouncer and the consuming control logic.
//   sync_in    : synchronized raw level (driven by master)
//   level_out  : debounced level
//   rise_pulse : one-cycle strobe on accepted 0->1
//   fall_pulse : one-cycle strobe on accepted 1->0
//   long_pulse : one-cycle long-press strobe (0 when feature disabled)
// master = synchronizer/consumer side, slave = debouncer.
interface debounce_edge_detect_if;
  logic sync_in;
  logic level_out;
  logic rise_pulse;
  logic fall_pulse;
  logic long_pulse;

  modport master (
    output sync_in,
    input  level_out, rise_pulse, fall_pulse, long_pulse
  );

  modport slave (
    input  sync_in,
    output level_out, rise_pulse, fall_pulse, long_pulse
  );
endinterface

// File: rtl/stable_counter.sv
// stable_counter: clear/set/increment counter with terminal-count compares.
//   clk, reset : clock, synchronous active-high reset
//   clr        : force count to 0 (highest priority)
//   set        : force count to 1 (first sample of a new level)
//   inc        : count+1, saturating at TERM (never wraps)
//   term       : count == TERM
//   near       : count == TERM-1 (TERM must be >= 1)
module stable_counter #(
  parameter int W    = 4,
  parameter int TERM = 3
) (
  input  logic clk,
  input  logic reset,
  input  logic clr,
  input  logic set,
  input  logic inc,
  output logic term,
  output logic near
);

  localparam logic [W-1:0] TERM_V = W'(TERM);
  localparam logic [W-1:0] NEAR_V = W'(TERM - 1);

  logic [W-1:0] count_q, count_d;

  always_comb begin
    count_d = count_q;
    if (clr)                          count_d = '0;
    else if (set)                     count_d = W'(1);
    else if (inc && count_q != TERM_V) count_d = count_q + 1'b1;
  end

  always_ff @(posedge clk) begin
    if (reset) count_q <= '0;
    else       count_q <= count_d;
  end

  assign term = (count_q == TERM_V);
  assign near = (count_q == NEAR_V);

endmodule

// File: rtl/debounce_edge_detect.sv
// debounce_edge_detect: contact-bounce filter with rise/fall strobes.
// A level change is accepted only after DEBOUNCE_CYCLES consecutive samples
// of the new level; any shorter excursion restarts qualification at zero.
//   clk, reset : clock, synchronous active-high reset
//   bus        : debounce_edge_detect_if.slave (sync_in in; level_out,
//                rise_pulse, fall_pulse, long_pulse out, all registered)
// Optional: define DEBOUNCE_LONG_PRESS_EN to emit one long_pulse per press
// once the debounced level has stayed high for LONG_CYCLES cycles;
// otherwise long_pulse is tied to 0.
module debounce_edge_detect
  import debounce_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES,
  parameter int LONG_CYCLES     = DEF_LONG_CYCLES
) (
  input  logic                  clk,
  input  logic                  reset,
  debounce_edge_detect_if.slave bus
);

  localparam int CNT_W = $clog2(max_int(DEBOUNCE_CYCLES, LONG_CYCLES));

  state_e state_q, state_d;
  logic   level_q, level_d;
  logic   rise_q,  rise_d;
  logic   fall_q,  fall_d;

  logic deb_clr, deb_set, deb_inc;
  logic deb_term;
  logic deb_near_unused;

  // Counter holds the number of consecutive new-level samples seen so far;
  // reaching DEBOUNCE_CYCLES-1 while one more matching sample arrives
  // completes qualification.
  stable_counter #(
    .W    (CNT_W),
    .TERM (DEBOUNCE_CYCLES - 1)
  ) u_deb_cnt (
    .clk   (clk),
    .reset (reset),
    .clr   (deb_clr),
    .set   (deb_set),
    .inc   (deb_inc),
    .term  (deb_term),
    .near  (deb_near_unused)
  );

  always_comb begin
    state_d = state_q;
    level_d = level_q;
    rise_d  = 1'b0;
    fall_d  = 1'b0;
    deb_clr = 1'b0;
    deb_set = 1'b0;
    deb_inc = 1'b0;
    unique case (state_q)
      IDLE_LOW: begin
        if (bus.sync_in) begin
          state_d = WAIT_HIGH;
          deb_set = 1'b1;
        end else begin
          deb_clr = 1'b1;
        end
      end
      WAIT_HIGH: begin
        if (!bus.sync_in) begin
          state_d = IDLE_LOW;
          deb_clr = 1'b1;
        end else if (deb_term) begin
          state_d = IDLE_HIGH;
          deb_clr = 1'b1;
          level_d = 1'b1;
          rise_d  = 1'b1;
        end else begin
          deb_inc = 1'b1;
        end
      end
      IDLE_HIGH: begin
        if (!bus.sync_in) begin
          state_d = WAIT_LOW;
          deb_set = 1'b1;
        end else begin
          deb_clr = 1'b1;
        end
      end
      WAIT_LOW: begin
        if (bus.sync_in) begin
          state_d = IDLE_HIGH;
          deb_clr = 1'b1;
        end else if (deb_term) begin
          state_d = IDLE_LOW;
          deb_clr = 1'b1;
          level_d = 1'b0;
          fall_d  = 1'b1;
        end else begin
          deb_inc = 1'b1;
        end
      end
      default: begin
        state_d = IDLE_LOW;
        deb_clr = 1'b1;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE_LOW;
      level_q <= 1'b0;
      rise_q  <= 1'b0;
      fall_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      level_q <= level_d;
      rise_q  <= rise_d;
      fall_q  <= fall_d;
    end
  end

  assign bus.level_out  = level_q;
  assign bus.rise_pulse = rise_q;
  assign bus.fall_pulse = fall_q;

`ifdef DEBOUNCE_LONG_PRESS_EN
  logic lp_inc, lp_clr;
  logic lp_term, lp_near;
  logic long_q, long_d;

  // Count only cycles that begin and end in IDLE_HIGH, so entry and any
  // bounce into WAIT_LOW leave the count at zero.
  assign lp_inc = (state_q == IDLE_HIGH) && (state_d == IDLE_HIGH);
  assign lp_clr = !lp_inc;

  stable_counter #(
    .W    (CNT_W),
    .TERM (LONG_CYCLES - 1)
  ) u_lp_cnt (
    .clk   (clk),
    .reset (reset),
    .clr   (lp_clr),
    .set   (1'b0),
    .inc   (lp_inc),
    .term  (lp_term),
    .near  (lp_near)
  );

  // Fire on the step into LONG_CYCLES-1; saturation keeps near low after.
  always_comb begin
    long_d = lp_inc && lp_near && !lp_term;
  end

  always_ff @(posedge clk) begin
    if (reset) long_q <= 1'b0;
    else       long_q <= long_d;
  end

  assign bus.long_pulse = long_q;
`else
  assign bus.long_pulse = 1'b0;
`endif

endmodule

// File: tb/tb_debounce_edge_detect.sv
// tb_debounce_edge_detect: directed, table-driven check of the debouncer
// with DEBOUNCE_CYCLES=4, LONG_CYCLES=10.
module tb_debounce_edge_detect;

  localparam int DEB  = 4;
  localparam int LONG = 10;
`ifdef DEBOUNCE_LONG_PRESS_EN
  localparam logic LP = 1'b1;
`else
  localparam logic LP = 1'b0;
`endif

  typedef struct {
    logic in;
    logic lvl;
    logic rise;
    logic fall;
    logic lng;
  } vec_t;

  logic clk = 1'b0;
  logic reset = 1'b1;
  int   checks = 0;
  int   errors = 0;
  vec_t vecs[$];

  debounce_edge_detect_if bus ();

  debounce_edge_detect #(
    .DEBOUNCE_CYCLES (DEB),
    .LONG_CYCLES     (LONG)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic act, input logic exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got %b want %b", name, act, exp);
    end
  endtask

  task automatic chk_all(input string tag, input logic lvl, input logic rise,
                         input logic fall, input logic lng);
    chk({tag, " level"}, bus.level_out, lvl);
    chk({tag, " rise"},  bus.rise_pulse, rise);
    chk({tag, " fall"},  bus.fall_pulse, fall);
    chk({tag, " long"},  bus.long_pulse, lng);
  endtask

  // Drive sync_in, take one rising edge, sample 1 time unit later.
  task automatic step(input logic s);
    bus.sync_in = s;
    @(posedge clk);
    #1;
  endtask

  task automatic add(input logic in, input logic lvl, input logic rise,
                     input logic fall, input logic lng);
    vec_t v;
    v.in = in; v.lvl = lvl; v.rise = rise; v.fall = fall; v.lng = lng;
    vecs.push_back(v);
  endtask

  initial begin
    // Idle low for 20 cycles.
    for (int i = 0; i < 20; i++) add(0, 0, 0, 0, 0);
    // Clean rise: level on the 4th consecutive high sample.
    for (int i = 0; i < DEB - 1; i++) add(1, 0, 0, 0, 0);
    add(1, 1, 1, 0, 0);
    add(1, 1, 0, 0, 0);
    // 3-cycle drop is rejected.
    for (int i = 0; i < 3; i++) add(0, 1, 0, 0, 0);
    add(1, 1, 0, 0, 0);
    add(1, 1, 0, 0, 0);
    // 4-cycle drop is accepted.
    for (int i = 0; i < 3; i++) add(0, 1, 0, 0, 0);
    add(0, 0, 0, 1, 0);
    add(0, 0, 0, 0, 0);
    // Bounce 1,1,1,0,1,1,1,0 then steady 1.
    for (int r = 0; r < 2; r++) begin
      for (int i = 0; i < 3; i++) add(1, 0, 0, 0, 0);
      add(0, 0, 0, 0, 0);
    end
    for (int i = 0; i < 3; i++) add(1, 0, 0, 0, 0);
    add(1, 1, 1, 0, 0);
    // Long press: 9th edge after the rise reaches LONG-1, then 50 quiet.
    for (int i = 0; i < LONG - 2; i++) add(1, 1, 0, 0, 0);
    add(1, 1, 0, 0, LP);
    for (int i = 0; i < 50; i++) add(1, 1, 0, 0, 0);
    // Release.
    for (int i = 0; i < 3; i++) add(0, 1, 0, 0, 0);
    add(0, 0, 0, 1, 0);
    add(0, 0, 0, 0, 0);

    // Reset state.
    bus.sync_in = 1'b0;
    reset = 1'b1;
    step(0);
    step(0);
    chk_all("reset", 0, 0, 0, 0);

    // Reset held with sync_in=1 must not produce strobes.
    step(1);
    chk_all("reset_hi", 0, 0, 0, 0);

    // Reset while WAIT_HIGH with count=3 aborts the rise.
    reset = 1'b0;
    for (int i = 0; i < 3; i++) begin
      step(1);
      chk($sformatf("pre_abort%0d level", i), bus.level_out, 1'b0);
    end
    reset = 1'b1;
    step(1);
    chk_all("abort", 0, 0, 0, 0);
    reset = 1'b0;
    for (int i = 0; i < 3; i++) begin
      step(1);
      chk_all($sformatf("fresh%0d", i), 0, 0, 0, 0);
    end
    step(1);
    chk_all("fresh_rise", 1, 1, 0, 0);
    step(1);
    chk_all("fresh_hold", 1, 0, 0, 0);

    // Back to IDLE_LOW for the table.
    reset = 1'b1;
    step(0);
    reset = 1'b0;
    chk_all("reset2", 0, 0, 0, 0);

    foreach (vecs[i]) begin
      step(vecs[i].in);
      chk_all($sformatf("vec%0d", i), vecs[i].lvl, vecs[i].rise,
              vecs[i].fall, vecs[i].lng);
      chk($sformatf("vec%0d excl", i),
          bus.rise_pulse & bus.fall_pulse, 1'b0);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
